anc_saturation: RTL and testbench



---
 rtl/anc_saturation_pkg.sv | 12 +
 rtl/anc_clip.sv | 24 ++
 rtl/anc_saturation.sv | 81 ++++++++
 tb/tb_anc_saturation.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/anc_saturation_pkg.sv
// Shared constants and types for the ANC output conditioning path.
// Filter and DAC blocks import this so they agree on limits.
package anc_saturation_pkg;

  localparam int SAMPLE_W = 11;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam int SAT_MAX_DEF = 1023;
  localparam int SAT_MIN_DEF = -1023;

endpackage

// File: rtl/anc_clip.sv
// Signed clip of a WIDTH+1 value into WIDTH bits between SAT_MIN/SAT_MAX.
// Purely combinational; instantiated once per output path.
module anc_clip #(
  parameter int WIDTH   = 11,
  parameter int SAT_MAX = 1023,
  parameter int SAT_MIN = -1023
) (
  input  logic signed [WIDTH:0]   x_i,
  output logic signed [WIDTH-1:0] y_o
);

  localparam logic signed [WIDTH:0] HI = (WIDTH+1)'(SAT_MAX);
  localparam logic signed [WIDTH:0] LO = (WIDTH+1)'(SAT_MIN);

  always_comb begin
    y_o = x_i[WIDTH-1:0];
    unique case (1'b1)
      (x_i > HI): y_o = HI[WIDTH-1:0];
      (x_i < LO): y_o = LO[WIDTH-1:0];
      default:    y_o = x_i[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/anc_saturation.sv
// ANC output stage: inverts and clips the filter output for the DAC,
// and offset-corrects and clips the mic sample for the LMS update.
module anc_saturation
  import anc_saturation_pkg::*;
#(
  parameter int WIDTH      = SAMPLE_W,
  parameter int SAT_MAX    = SAT_MAX_DEF,
  parameter int SAT_MIN    = SAT_MIN_DEF,
  parameter int MIC_OFFSET = 0
) (
  input  logic             Clk_100M,
  input  logic             Rst,
  input  logic [WIDTH-1:0] FiltIn,
  input  logic [WIDTH-1:0] MicIn,
  input  logic             FiltComplete,
  output logic [WIDTH-1:0] Err,
  output logic [WIDTH-1:0] ANCAudioOut
);

  localparam logic signed [WIDTH:0] OFF = (WIDTH+1)'(MIC_OFFSET);

  logic                    fc_q, fc_d;
  logic [WIDTH-1:0]        anc_q, anc_d;
  logic [WIDTH-1:0]        err_q, err_d;
  logic                    load;
  logic signed [WIDTH:0]   anti;
  logic signed [WIDTH:0]   e;
  logic signed [WIDTH-1:0] anc_clip_w;
  logic signed [WIDTH-1:0] err_clip_w;

  // One extra bit so negating the most-negative sample cannot wrap.
  always_comb begin
    anti = -$signed({FiltIn[WIDTH-1], FiltIn});
    e    = $signed({MicIn[WIDTH-1], MicIn}) - OFF;
  end

  anc_clip #(
    .WIDTH   (WIDTH),
    .SAT_MAX (SAT_MAX),
    .SAT_MIN (SAT_MIN)
  ) u_clip_anc (
    .x_i (anti),
    .y_o (anc_clip_w)
  );

  anc_clip #(
    .WIDTH   (WIDTH),
    .SAT_MAX (SAT_MAX),
    .SAT_MIN (SAT_MIN)
  ) u_clip_err (
    .x_i (e),
    .y_o (err_clip_w)
  );

  always_comb begin
    fc_d  = FiltComplete;
    load  = FiltComplete & ~fc_q;
    anc_d = anc_q;
    err_d = err_q;
    if (load) begin
      anc_d = anc_clip_w;
      err_d = err_clip_w;
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (Rst) begin
      fc_q  <= 1'b0;
      anc_q <= '0;
      err_q <= '0;
    end else begin
      fc_q  <= fc_d;
      anc_q <= anc_d;
      err_q <= err_d;
    end
  end

  assign Err         = err_q;
  assign ANCAudioOut = anc_q;

endmodule

// File: tb/tb_anc_saturation.sv
// Randomized and directed checks of anc_saturation against an
// integer reference model, across three parameterisations.
module tb_anc_saturation;
  import anc_saturation_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  sample_t filt_in;
  sample_t mic_in;
  logic    fc;
  logic [10:0] err0, err1, err2;
  logic [10:0] anc0, anc1, anc2;

  always #5 clk = ~clk;

  anc_saturation u_dut0 (
    .Clk_100M(clk), .Rst(rst), .FiltIn(filt_in), .MicIn(mic_in),
    .FiltComplete(fc), .Err(err0), .ANCAudioOut(anc0)
  );

  anc_saturation #(
    .SAT_MAX(500), .SAT_MIN(-500)
  ) u_dut1 (
    .Clk_100M(clk), .Rst(rst), .FiltIn(filt_in), .MicIn(mic_in),
    .FiltComplete(fc), .Err(err1), .ANCAudioOut(anc1)
  );

  anc_saturation #(
    .MIC_OFFSET(100)
  ) u_dut2 (
    .Clk_100M(clk), .Rst(rst), .FiltIn(filt_in), .MicIn(mic_in),
    .FiltComplete(fc), .Err(err2), .ANCAudioOut(anc2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int mx[3]  = '{1023, 500, 1023};
  int mn[3]  = '{-1023, -500, -1023};
  int off[3] = '{0, 0, 100};
  int anc_m[3];
  int err_m[3];
  bit fc_prev;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clipi(input int x, input int hi, input int lo);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic int sv(input logic [10:0] v);
    return int'($signed(v));
  endfunction

  // Advance one clock, update the model, then compare all outputs.
  task automatic step();
    int f, m;
    bit strobe;
    f = int'(filt_in);
    m = int'(mic_in);
    strobe = fc && !fc_prev;
    @(posedge clk);
    if (rst) begin
      fc_prev = 0;
      for (int i = 0; i < 3; i++) begin
        anc_m[i] = 0;
        err_m[i] = 0;
      end
    end else begin
      fc_prev = fc;
      if (strobe)
        for (int i = 0; i < 3; i++) begin
          anc_m[i] = clipi(-f, mx[i], mn[i]);
          err_m[i] = clipi(m - off[i], mx[i], mn[i]);
        end
    end
    #1;
    chk("anc0", sv(anc0), anc_m[0]);
    chk("err0", sv(err0), err_m[0]);
    chk("anc1", sv(anc1), anc_m[1]);
    chk("err1", sv(err1), err_m[1]);
    chk("anc2", sv(anc2), anc_m[2]);
    chk("err2", sv(err2), err_m[2]);
  endtask

  task automatic load(input int f, input int m);
    fc = 1'b0;
    step();
    filt_in = sample_t'(f);
    mic_in  = sample_t'(m);
    fc = 1'b1;
    step();
  endtask

  initial begin
    fc_prev = 0;
    for (int i = 0; i < 3; i++) begin
      anc_m[i] = 0;
      err_m[i] = 0;
    end
    rst = 1'b1;
    filt_in = 11'sd100;
    mic_in  = 11'sd50;
    fc = 1'b0;
    repeat (2) begin
      fc = ~fc;
      step();
    end
    chk("rst_anc", sv(anc0), 0);
    chk("rst_err", sv(err0), 0);

    // FiltComplete already high right after reset counts as an edge.
    rst = 1'b0;
    fc = 1'b1;
    step();
    chk("post_rst_anc", sv(anc0), -100);
    chk("post_rst_err", sv(err0), 50);

    fc = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    filt_in = sample_t'(2000);
    mic_in  = 11'sd9;
    repeat (10) step();
    chk("pre_edge_anc", sv(anc0), 0);
    fc = 1'b1;
    step();
    chk("basic_anc", sv(anc0), 48);
    chk("basic_err", sv(err0), 9);
    filt_in = 11'sd77;
    mic_in  = 11'sd5;
    repeat (3) step();
    chk("hold_anc", sv(anc0), 48);
    chk("hold_err", sv(err0), 9);

    load(-1024, 1023);
    chk("sat_pos_anc", sv(anc0), 1023);
    chk("sat_pos_err", sv(err0), 1023);
    load(1023, 0);
    chk("at_min_anc", sv(anc0), -1023);

    load(600, -700);
    chk("neg_sat_anc", sv(anc1), -500);
    chk("neg_sat_err", sv(err1), -500);
    load(-500, 0);
    chk("lim_anc", sv(anc1), 500);

    load(0, -1000);
    chk("off_neg_err", sv(err2), -1023);
    load(0, 300);
    chk("off_pos_err", sv(err2), 200);

    fc = 1'b0;
    step();
    for (int k = 1; k <= 3; k++) begin
      filt_in = sample_t'(10 * k);
      fc = 1'b1;
      step();
      chk("pulse_anc", sv(anc0), -10 * k);
      fc = 1'b0;
      filt_in = 11'sd0;
      repeat (3) step();
    end

    rst = 1'b1;
    step();
    chk("mid_rst_anc", sv(anc0), 0);
    rst = 1'b0;

    for (int c = 0; c < 400; c++) begin
      filt_in = sample_t'($urandom);
      mic_in  = sample_t'($urandom);
      fc  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
